// File: rtl/ahb_split_sram_slave.sv
// ahb_split_sram_slave: word-addressed 32-bit SRAM slave for AHB-Lite/AHB2.
// Adds programmable wait states, two-cycle ERROR responses and, optionally,
// SPLIT responses with a timed HSPLIT release to the arbiter.
//
// Optional feature macro: AHB_SLAVE_SPLIT_EN
//   defined   - unlocked NONSEQ from a master without a token is SPLIT and
//               released SPLIT_LATENCY cycles later through HSPLIT
//   undefined - no split logic, HSPLIT tied to zero, SPLIT never returned
//
// Ports:
//   HCLK, HRESETn       clock, asynchronous active-low reset
//   HSEL, HREADY        decoder select, bus-wide ready (address phase qualifier)
//   HADDR, HTRANS       address (bits [ADDR_W+1:2] index the memory), transfer type
//   HWRITE, HSIZE       direction, size (byte/half/word; larger sizes get ERROR)
//   HBURST              accepted and ignored
//   HWDATA              write data, sampled in the data phase
//   HMASTER, HMASTLOCK  address-phase master number, locked transfer flag
//   HREADYOUT, HRESP    slave ready and response (OKAY/ERROR/SPLIT)
//   HRDATA              read data, zero outside the final read data cycle
//   HSPLIT              one-cycle master release mask

module ahb_split_sram_slave #(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned WAIT_STATES   = 1,
    parameter int unsigned SPLIT_LATENCY = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [3:0]  HMASTER,
    input  logic        HMASTLOCK,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic [15:0] HSPLIT
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned SCNT_W = 8;

    localparam logic [1:0] TR_NONSEQ  = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3,
        ST_SPL1 = 3'd4,
        ST_SPL2 = 3'd5
    } state_t;

    state_t              st, st_nxt;
    logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
    logic                dp, dp_nxt;
    logic [ADDR_W-1:0]   a_idx, a_idx_nxt;
    logic [1:0]          a_off;
    logic [2:0]          a_size;
    logic                a_write, a_write_nxt;

    logic                rdy_state;
    logic                accept;
    logic                is_err;
    logic                is_split;
    logic                wr_en;
    logic [3:0]          wr_be;
    logic [31:0]         cur_word;
    logic [31:0]         wr_word;
    logic [31:0]         rd_word;
    logic                ready_nxt;
    logic [1:0]          resp_nxt;
    logic [31:0]         rdata_nxt;

    logic [31:0]         mem [DEPTH];

    logic                unused_bits;
    assign unused_bits = ^{HBURST, HADDR[31:ADDR_W+2]};

    // States in which this slave drives HREADYOUT high
    assign rdy_state = (st != ST_WAIT) && (st != ST_ERR1) && (st != ST_SPL1);
    assign accept    = HSEL && HREADY && HTRANS[1] && rdy_state;

    assign is_err = (HSIZE > 3'd2)
                 || ((HSIZE == 3'd1) && HADDR[0])
                 || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    assign a_idx_nxt   = accept ? HADDR[ADDR_W+1:2] : a_idx;
    assign a_write_nxt = accept ? HWRITE : a_write;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st   <= ST_IDLE;
            wcnt <= '0;
            dp   <= 1'b0;
        end else begin
            st   <= st_nxt;
            wcnt <= wcnt_nxt;
            dp   <= dp_nxt;
        end
    end

    // Next-state logic; dp marks a normal data phase in progress
    always_comb begin
        st_nxt   = st;
        wcnt_nxt = wcnt;
        dp_nxt   = dp;
        case (st)
            ST_WAIT: begin
                if (wcnt == WCNT_W'(1)) st_nxt = ST_IDLE;
                else                    wcnt_nxt = wcnt - WCNT_W'(1);
            end
            ST_ERR1: st_nxt = ST_ERR2;
            ST_SPL1: st_nxt = ST_SPL2;
            default: begin
                st_nxt = ST_IDLE;
                dp_nxt = 1'b0;
                if (accept) begin
                    if (is_err) begin
                        st_nxt = ST_ERR1;
                    end else if (is_split) begin
                        st_nxt = ST_SPL1;
                    end else begin
                        dp_nxt = 1'b1;
                        if (WAIT_STATES != 0) begin
                            st_nxt   = ST_WAIT;
                            wcnt_nxt = WCNT_W'(WAIT_STATES);
                        end
                    end
                end
            end
        endcase
    end

    // Output decode from the next state, registered below
    always_comb begin
        ready_nxt = 1'b1;
        resp_nxt  = RESP_OKAY;
        rdata_nxt = '0;
        case (st_nxt)
            ST_WAIT: ready_nxt = 1'b0;
            ST_ERR1: begin
                ready_nxt = 1'b0;
                resp_nxt  = RESP_ERROR;
            end
            ST_ERR2: resp_nxt = RESP_ERROR;
            ST_SPL1: begin
                ready_nxt = 1'b0;
                resp_nxt  = RESP_SPLIT;
            end
            ST_SPL2: resp_nxt = RESP_SPLIT;
            default: ;
        endcase
        if ((st_nxt == ST_IDLE) && dp_nxt && !a_write_nxt) rdata_nxt = rd_word;
    end

    // Output register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
            HRDATA    <= '0;
        end else begin
            HREADYOUT <= ready_nxt;
            HRESP     <= resp_nxt;
            HRDATA    <= rdata_nxt;
        end
    end

    // Address-phase latch
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_idx   <= '0;
            a_off   <= '0;
            a_size  <= '0;
            a_write <= 1'b0;
        end else begin
            a_idx   <= a_idx_nxt;
            a_write <= a_write_nxt;
            if (accept) begin
                a_off  <= HADDR[1:0];
                a_size <= HSIZE;
            end
        end
    end

    // Little-endian byte-lane enables
    always_comb begin
        wr_be = 4'b1111;
        case (a_size)
            3'd0:    wr_be = 4'b0001 << a_off;
            3'd1:    wr_be = a_off[1] ? 4'b1100 : 4'b0011;
            default: wr_be = 4'b1111;
        endcase
    end

    assign wr_en    = dp && rdy_state && a_write;
    assign cur_word = mem[a_idx];

    always_comb begin
        wr_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    // A read accepted on the edge that retires a write to the same word sees the new data
    assign rd_word = (wr_en && (a_idx == a_idx_nxt)) ? wr_word : mem[a_idx_nxt];

    // Memory array, not reset
    always_ff @(posedge HCLK) begin
        if (wr_en) mem[a_idx] <= wr_word;
    end

`ifdef AHB_SLAVE_SPLIT_EN
    logic [15:0]       pending;
    logic [15:0]       token;
    logic [15:0]       new_bit;
    logic [15:0]       tok_clr;
    logic [SCNT_W-1:0] scnt;
    logic              release_now;

    assign is_split    = (HTRANS == TR_NONSEQ) && !HMASTLOCK && !token[HMASTER];
    assign new_bit     = (accept && !is_err && is_split) ? (16'd1 << HMASTER) : 16'd0;
    assign tok_clr     = (accept && (HTRANS == TR_NONSEQ) && token[HMASTER]) ? (16'd1 << HMASTER) : 16'd0;
    assign release_now = (pending != 16'd0) && (scnt <= SCNT_W'(1));

    // Split bookkeeping: a split landing on the release edge joins the next round
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending <= '0;
            token   <= '0;
            scnt    <= '0;
            HSPLIT  <= '0;
        end else begin
            HSPLIT  <= release_now ? pending : 16'd0;
            pending <= (release_now ? 16'd0 : pending) | new_bit;
            token   <= (token & ~tok_clr) | (release_now ? pending : 16'd0);
            if (release_now) begin
                scnt <= (new_bit != 16'd0) ? SCNT_W'(SPLIT_LATENCY) : SCNT_W'(0);
            end else if (pending == 16'd0) begin
                if (new_bit != 16'd0) scnt <= SCNT_W'(SPLIT_LATENCY);
            end else begin
                scnt <= scnt - SCNT_W'(1);
            end
        end
    end
`else
    logic unused_split;
    assign unused_split = ^{HMASTER, HMASTLOCK, HTRANS[0]};
    assign is_split     = 1'b0;
    assign HSPLIT       = '0;
`endif

endmodule
